// File: rtl/time_syn_rx.sv
// Time-sync RX frame parser: classifies 8-beat AXIS frames by preamble, commits beat-1 time
// with arrival stamp. Optional exact-length check enabled by TIME_SYN_RX_LEN_CHECK_EN.
module time_syn_rx #(
  parameter int          P_FRAME_LEN  = 8,
  parameter logic [63:0] P_TS_PRE     = 64'h66,
  parameter logic [63:0] P_STD_PRE    = 64'h88,
  parameter logic [63:0] P_RETURN_PRE = 64'h55
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_local_time,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_recv_ts_valid,
  output logic        o_recv_std_valid,
  output logic        o_recv_return_valid,
  output logic [63:0] o_recv_time,
  output logic [63:0] o_arrival_time,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, DROP} state_t;
  typedef enum logic [1:0] {T_TS, T_STD, T_RET, T_NONE} ftype_t;

  state_t      state, state_nxt;
  ftype_t      frm_type, pre_type;
  logic [63:0] time_cand, arr_cand;
  logic [15:0] beat_cnt, beat_inc;
  logic        frm_bad, keep_ok, len_ok, beat, commit, discard;

  assign beat     = i_rx_axis_tvalid;
  assign keep_ok  = (i_rx_axis_tkeep == 8'hff);
  assign beat_inc = (beat_cnt == 16'hffff) ? beat_cnt : beat_cnt + 16'd1;

  always_comb begin
    pre_type = T_NONE;
    if      (i_rx_axis_tdata == P_TS_PRE)     pre_type = T_TS;
    else if (i_rx_axis_tdata == P_STD_PRE)    pre_type = T_STD;
    else if (i_rx_axis_tdata == P_RETURN_PRE) pre_type = T_RET;
  end

  // beat_inc is the total length including the current (tlast) beat
`ifdef TIME_SYN_RX_LEN_CHECK_EN
  assign len_ok = (beat_inc == 16'(P_FRAME_LEN));
`else
  assign len_ok = (beat_inc >= 16'd2);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    discard   = 1'b0;
    case (state)
      IDLE: if (beat) begin
        if (i_rx_axis_tlast)       discard   = 1'b1;
        else if (pre_type != T_NONE) state_nxt = PAYLOAD;
        else                       state_nxt = DROP;
      end
      PAYLOAD: if (beat) begin
        if (i_rx_axis_tlast) begin
          discard   = 1'b1;
          state_nxt = IDLE;
        end else state_nxt = DRAIN;
      end
      DRAIN: if (beat && i_rx_axis_tlast) begin
        state_nxt = IDLE;
        if (!frm_bad && keep_ok && !i_rx_axis_tuser && len_ok) commit  = 1'b1;
        else                                                   discard = 1'b1;
      end
      DROP: if (beat && i_rx_axis_tlast) begin
        discard   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frm_type            <= T_NONE;
      time_cand           <= '0;
      arr_cand            <= '0;
      beat_cnt            <= '0;
      frm_bad             <= 1'b0;
      o_recv_ts_valid     <= 1'b0;
      o_recv_std_valid    <= 1'b0;
      o_recv_return_valid <= 1'b0;
      o_recv_time         <= '0;
      o_arrival_time      <= '0;
      o_drop_cnt          <= '0;
    end else begin
      o_recv_ts_valid     <= 1'b0;
      o_recv_std_valid    <= 1'b0;
      o_recv_return_valid <= 1'b0;
      if (state == IDLE && beat && !i_rx_axis_tlast && pre_type != T_NONE) begin
        frm_type <= pre_type;
        arr_cand <= i_local_time;
        frm_bad  <= !keep_ok;
        beat_cnt <= 16'd1;
      end
      if (state == PAYLOAD && beat && !i_rx_axis_tlast) begin
        time_cand <= i_rx_axis_tdata;
        frm_bad   <= frm_bad | !keep_ok;
        beat_cnt  <= beat_inc;
      end
      if (state == DRAIN && beat) begin
        frm_bad  <= frm_bad | !keep_ok;
        beat_cnt <= beat_inc;
      end
      if (commit) begin
        o_recv_time         <= time_cand;
        o_arrival_time      <= arr_cand;
        o_recv_ts_valid     <= (frm_type == T_TS);
        o_recv_std_valid    <= (frm_type == T_STD);
        o_recv_return_valid <= (frm_type == T_RET);
      end
      if (discard && o_drop_cnt != 16'hffff) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_time_syn_rx.sv
// Directed self-checking bench for time_syn_rx; expectations are hand-computed per frame.
module tb_time_syn_rx;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic [63:0] i_local_time = '0;
  logic        i_rx_axis_tvalid = 1'b0, i_rx_axis_tlast = 1'b0, i_rx_axis_tuser = 1'b0;
  logic [63:0] i_rx_axis_tdata = '0;
  logic [7:0]  i_rx_axis_tkeep = 8'hff;
  logic        o_recv_ts_valid, o_recv_std_valid, o_recv_return_valid;
  logic [63:0] o_recv_time, o_arrival_time;
  logic [15:0] o_drop_cnt;

  int checks = 0, errors = 0;
  int cyc = 0, n_ts = 0, n_std = 0, n_ret = 0, multi = 0;
  int t_std = 0, t_ret = 0;
  logic [63:0] std_time = '0, ret_time = '0, ret_arr = '0;

  time_syn_rx dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_local_time(i_local_time),
    .i_rx_axis_tvalid(i_rx_axis_tvalid), .i_rx_axis_tdata(i_rx_axis_tdata),
    .i_rx_axis_tlast(i_rx_axis_tlast), .i_rx_axis_tkeep(i_rx_axis_tkeep),
    .i_rx_axis_tuser(i_rx_axis_tuser), .o_recv_ts_valid(o_recv_ts_valid),
    .o_recv_std_valid(o_recv_std_valid), .o_recv_return_valid(o_recv_return_valid),
    .o_recv_time(o_recv_time), .o_arrival_time(o_arrival_time), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // pulse monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (32'(o_recv_ts_valid) + 32'(o_recv_std_valid) + 32'(o_recv_return_valid) > 1) multi <= multi + 1;
    if (o_recv_ts_valid) n_ts <= n_ts + 1;
    if (o_recv_std_valid) begin n_std <= n_std + 1; t_std <= cyc; std_time <= o_recv_time; end
    if (o_recv_return_valid) begin
      n_ret <= n_ret + 1; t_ret <= cyc; ret_time <= o_recv_time; ret_arr <= o_arrival_time;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int i, input logic [63:0] pre, input logic [63:0] pl);
    if (i == 0) return pre;
    if (i == 1) return pl;
    return 64'h1000 + 64'(i);
  endfunction

  // drive one frame; local time = lt + beat index; optional one-cycle gap before beat gap_at
  task automatic send_frame(input logic [63:0] pre, input logic [63:0] pl, input int len,
                            input logic [63:0] lt, input logic tuser, input int bad_keep,
                            input int gap_at);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        @(negedge i_clk);
        i_rx_axis_tvalid = 1'b0;
        i_rx_axis_tdata  = 64'h66;
      end
      @(negedge i_clk);
      i_rx_axis_tvalid = 1'b1;
      i_rx_axis_tdata  = beat_data(i, pre, pl);
      i_local_time     = lt + 64'(i);
      i_rx_axis_tlast  = (i == len - 1);
      i_rx_axis_tuser  = (i == len - 1) ? tuser : 1'b0;
      i_rx_axis_tkeep  = (i == bad_keep) ? 8'h0f : 8'hff;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_rx_axis_tvalid = 1'b0;
      i_rx_axis_tlast  = 1'b0;
      i_rx_axis_tuser  = 1'b0;
      i_rx_axis_tkeep  = 8'hff;
    end
  endtask

  initial begin
    int base;
    repeat (3) @(negedge i_clk);
    check("rst_drop", 64'(o_drop_cnt), 0);
    check("rst_time", o_recv_time, 0);
    check("rst_arr", o_arrival_time, 0);
    check("rst_pulse", {61'd0, o_recv_ts_valid, o_recv_std_valid, o_recv_return_valid}, 0);
    i_rst = 1'b0;
    idle(2);

    // basic 0x66 frame: pulse visible exactly one cycle after tlast
    send_frame(64'h66, 64'h1234, 8, 64'h500, 1'b0, -1, -1);
    idle(1);
    check("ts_pulse", 64'(o_recv_ts_valid), 1);
    check("ts_time", o_recv_time, 64'h1234);
    check("ts_arr", o_arrival_time, 64'h500);
    idle(1);
    check("ts_pulse_1cyc", 64'(o_recv_ts_valid), 0);

    // back-to-back std then return
    send_frame(64'h88, 64'hABCD, 8, 64'h600, 1'b0, -1, -1);
    send_frame(64'h55, 64'h77, 8, 64'h700, 1'b0, -1, -1);
    idle(3);
    check("b2b_std_n", 64'(n_std), 1);
    check("b2b_ret_n", 64'(n_ret), 1);
    check("b2b_spacing", 64'(t_ret - t_std), 8);
    check("b2b_std_time", std_time, 64'hABCD);
    check("b2b_ret_time", ret_time, 64'h77);
    check("b2b_ret_arr", ret_arr, 64'h700);

    // bad preamble: dropped, counter increments one cycle after tlast
    send_frame(64'h99, 64'h1, 8, 64'h800, 1'b0, -1, -1);
    idle(1);
    check("bad_pre_drop", 64'(o_drop_cnt), 1);
    check("bad_pre_time", o_recv_time, 64'h77);
    send_frame(64'h66, 64'h42, 8, 64'h900, 1'b0, -1, 3);  // with in-frame gap
    idle(2);
    check("after_bad_ts_n", 64'(n_ts), 2);
    check("after_bad_time", o_recv_time, 64'h42);
    check("after_bad_arr", o_arrival_time, 64'h900);

    // tuser on tlast
    send_frame(64'h66, 64'h999, 8, 64'hA00, 1'b0 | 1'b1, -1, -1);
    idle(2);
    check("tuser_drop", 64'(o_drop_cnt), 2);
    check("tuser_time", o_recv_time, 64'h42);
    check("tuser_ts_n", 64'(n_ts), 2);

    // partial tkeep on beat 3
    send_frame(64'h88, 64'h333, 8, 64'hB00, 1'b0, 3, -1);
    idle(2);
    check("tkeep_drop", 64'(o_drop_cnt), 3);
    check("tkeep_std_n", 64'(n_std), 1);

    // single-beat frame: tlast on preamble
    send_frame(64'h66, 64'h0, 1, 64'hC00, 1'b0, -1, -1);
    idle(2);
    check("len1_drop", 64'(o_drop_cnt), 4);

    // 6-beat frame
    send_frame(64'h66, 64'h6666, 6, 64'hD00, 1'b0, -1, -1);
    idle(2);
`ifdef TIME_SYN_RX_LEN_CHECK_EN
    check("len6_drop", 64'(o_drop_cnt), 5);
    check("len6_time", o_recv_time, 64'h42);
`else
    check("len6_drop", 64'(o_drop_cnt), 4);
    check("len6_time", o_recv_time, 64'h6666);
    check("len6_arr", o_arrival_time, 64'hD00);
`endif

    // reset during beat 3 of a 0x88 frame; tail of that frame is dropped
    base = n_std;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_rx_axis_tvalid = 1'b1;
      i_rx_axis_tdata  = beat_data(i, 64'h88, 64'hBEEF);
      i_rx_axis_tlast  = 1'b0;
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    i_rx_axis_tdata = beat_data(3, 64'h88, 64'hBEEF);
    #1;
    check("midrst_drop", 64'(o_drop_cnt), 0);
    check("midrst_time", o_recv_time, 0);
    check("midrst_arr", o_arrival_time, 0);
    for (int i = 4; i < 8; i++) begin
      @(negedge i_clk);
      i_rst = 1'b0;
      i_rx_axis_tvalid = 1'b1;
      i_rx_axis_tdata  = beat_data(i, 64'h88, 64'hBEEF);
      i_rx_axis_tlast  = (i == 7);
    end
    idle(2);
    check("midrst_tail_drop", 64'(o_drop_cnt), 1);
    check("midrst_no_pulse", 64'(n_std - base), 0);
    send_frame(64'h88, 64'h55AA, 8, 64'hE00, 1'b0, -1, -1);
    idle(2);
    check("post_rst_std_n", 64'(n_std - base), 1);
    check("post_rst_time", o_recv_time, 64'h55AA);
    check("post_rst_arr", o_arrival_time, 64'hE00);
    check("onehot_pulses", 64'(multi), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
